// File: rtl/instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetcher
// Description : Fetch front end. Holds the fetch PC, issues one instruction
//               cache read at a time, advances by 2 (RVC) or 4 bytes, and
//               queues fetched instructions toward the decoder. A flush port
//               redirects fetch and drops stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetcher #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] read_addr,
  output logic        is_reading,
  input  logic [31:0] read_data,
  input  logic        is_ready,
  input  logic        is_compressed_instruction,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed,
  input  logic        inst_ready
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [31:0]        pc, pc_n, addr_n, pc_inc, push_data;
  logic               reading_n, push, pop, room;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]   count, count_n;

  logic [31:0]        data_mem [QUEUE_DEPTH];
  logic [31:0]        pc_mem   [QUEUE_DEPTH];
  logic               comp_mem [QUEUE_DEPTH];

  // Next-state, request and FIFO bookkeeping; everything holds when rdy_in is low
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    addr_n    = read_addr;
    reading_n = is_reading;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count;
    push      = 1'b0;
    pop       = 1'b0;
    room      = 1'b0;
    push_data = is_compressed_instruction ? {16'h0, read_data[15:0]} : read_data;
    pc_inc    = pc + (is_compressed_instruction ? 32'd2 : 32'd4);
    if (rdy_in) begin
      if (flush_in) begin
        // Redirect: queue emptied, any same-cycle pop/push is void
        pc_n     = flush_pc;
        wr_ptr_n = '0;
        rd_ptr_n = '0;
        count_n  = '0;
        if (state != IDLE && !is_ready) begin
          // Old request still in flight: hold it and drop its answer
          state_n = DISCARD;
        end else begin
          state_n   = WAIT;
          addr_n    = flush_pc;
          reading_n = 1'b1;
        end
      end else begin
        pop  = inst_valid & inst_ready;
        push = (state == WAIT) & is_ready;
        if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
        if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
        count_n = count + CNT_W'(push) - CNT_W'(pop);
        // A new request reserves one slot on top of the queued entries
        room = (count_n < DEPTH_C);
        case (state)
          IDLE: begin
            if (room) begin
              state_n   = WAIT;
              addr_n    = pc;
              reading_n = 1'b1;
            end
          end
          WAIT: begin
            if (is_ready) begin
              pc_n = pc_inc;
              if (room) begin
                addr_n = pc_inc;
              end else begin
                state_n   = IDLE;
                reading_n = 1'b0;
              end
            end
          end
          DISCARD: begin
            if (is_ready) begin
              state_n = WAIT;
              addr_n  = pc;
            end
          end
          default: begin
            state_n   = IDLE;
            reading_n = 1'b0;
          end
        endcase
      end
    end
  end

  // Control and request registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      read_addr  <= RESET_PC;
      is_reading <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      read_addr  <= addr_n;
      is_reading <= reading_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
    end
  end

  // Instruction storage; cleared on reset so the head reads as zero
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
        comp_mem[i] <= 1'b0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= push_data;
      pc_mem[wr_ptr]   <= pc;
      comp_mem[wr_ptr] <= is_compressed_instruction;
    end
  end

  assign inst_valid         = (count != '0);
  assign inst_data          = data_mem[rd_ptr];
  assign inst_pc            = pc_mem[rd_ptr];
  assign inst_is_compressed = comp_mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetcher
// Description : Self-checking bench for instruction_fetcher: directed vector
//               table, reset sequences, and a randomized run against a
//               stream-level reference model with a behavioural cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetcher;

  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] read_addr;
  logic        is_reading;
  logic [31:0] read_data;
  logic        is_ready;
  logic        is_compressed_instruction;
  logic        flush_in;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;
  logic        inst_ready;

  int n_total = 0;
  int n_pass  = 0;

  instruction_fetcher #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .read_addr                 (read_addr),
    .is_reading                (is_reading),
    .read_data                 (read_data),
    .is_ready                  (is_ready),
    .is_compressed_instruction (is_compressed_instruction),
    .flush_in                  (flush_in),
    .flush_pc                  (flush_pc),
    .inst_valid                (inst_valid),
    .inst_data                 (inst_data),
    .inst_pc                   (inst_pc),
    .inst_is_compressed        (inst_is_compressed),
    .inst_ready                (inst_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy, rr, comp;
    logic [31:0] data;
    logic        fl;
    logic [31:0] fpc;
    logic        ir;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_data;
    logic        e_comp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic rr, logic comp, logic [31:0] data,
                              logic fl, logic [31:0] fpc, logic ir,
                              logic e_rd, logic [31:0] e_addr, logic e_v,
                              logic [31:0] e_pc, logic [31:0] e_data, logic e_comp);
    vec_t v;
    v.rdy = rdy; v.rr = rr; v.comp = comp; v.data = data; v.fl = fl; v.fpc = fpc;
    v.ir = ir; v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
    v.e_data = e_data; v.e_comp = e_comp;
    return v;
  endfunction

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ (a >> 5) ^ 32'h5A5AC3C3;
  endfunction
  function automatic logic mem_comp(logic [31:0] a);
    logic [31:0] h;
    h = mem_word(a);
    return h[7];
  endfunction
  function automatic logic [31:0] mem_inst(logic [31:0] a);
    logic [31:0] h;
    h = mem_word(a);
    return mem_comp(a) ? {16'h0, h[15:0]} : h;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        comp;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] fetch_pc;
  logic        stale, busy, last_rdy, primed;
  int          timer;

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; read_data = '0; is_ready = 1'b0;
    is_compressed_instruction = 1'b0; flush_in = 1'b0; flush_pc = '0; inst_ready = 1'b0;

    // Table: rdy rr comp data fl fpc ir | rd addr v pc data comp
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,1, 1,32'h0,        0,32'h0,32'h0,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,1, 1,32'h4,        1,32'h0,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,1, 1,32'h8,        1,32'h4,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,1, 1,32'hC,        1,32'h8,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,0, 1,32'h10,       1,32'h8,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,0, 1,32'h14,       1,32'h8,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,0, 0,32'h0,        1,32'h8,32'h13,0));
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,0, 0,32'h0,        1,32'h8,32'h13,0));
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,1, 1,32'h18,       1,32'hC,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,0, 0,32'h0,        1,32'hC,32'h13,0));
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,0, 0,32'h0,        1,32'hC,32'h13,0));
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,1, 1,32'h1C,       1,32'h10,32'h13,0));
    vecs.push_back(mk(1,0,0,32'h0,       1,32'h100,1, 1,32'h1C,     0,32'h0,32'h0,0));
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,1, 1,32'h1C,       0,32'h0,32'h0,0));
    vecs.push_back(mk(1,1,0,32'hDEADBEEF,0,32'h0,1, 1,32'h100,      0,32'h0,32'h0,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,0, 1,32'h104,      1,32'h100,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,0, 1,32'h108,      1,32'h100,32'h13,0));
    vecs.push_back(mk(1,1,0,32'hCAFEF00D,1,32'h200,1, 1,32'h200,    0,32'h0,32'h0,0));
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,1, 1,32'h200,      0,32'h0,32'h0,0));
    vecs.push_back(mk(1,1,0,32'h11111111,1,32'h80000000,1, 1,32'h80000000, 0,32'h0,32'h0,0));
    vecs.push_back(mk(1,1,1,32'hABCD0001,0,32'h0,1, 1,32'h80000002, 1,32'h80000000,32'h00000001,1));
    vecs.push_back(mk(1,1,1,32'h12344502,0,32'h0,1, 1,32'h80000004, 1,32'h80000002,32'h00004502,1));
    vecs.push_back(mk(1,1,0,32'h00A00093,0,32'h0,1, 1,32'h80000008, 1,32'h80000004,32'h00A00093,0));
    vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,0, 1,32'h80000008, 1,32'h80000004,32'h00A00093,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,i[0],0,32'h55555555, (i==1 || i==3) ? 1'b1 : 1'b0, 32'h40, 1,
                        1,32'h80000008, 1,32'h80000004,32'h00A00093,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,1, 1,32'h8000000C, 1,32'h80000008,32'h13,0));
    vecs.push_back(mk(1,1,0,32'h0,       1,32'hFFFFFFFC,1, 1,32'hFFFFFFFC, 0,32'h0,32'h0,0));
    vecs.push_back(mk(1,1,0,32'h13,      0,32'h0,0, 1,32'h0,        1,32'hFFFFFFFC,32'h13,0));

    // Reset values
    repeat (3) @(negedge clk_in);
    check("rst_is_reading", 32'(is_reading), 32'h0);
    check("rst_read_addr", read_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_comp", 32'(inst_is_compressed), 32'h0);
    rst_in = 1'b1;

    // Directed table: apply at a falling edge, check at the next one
    foreach (vecs[i]) begin
      rdy_in = vecs[i].rdy; is_ready = vecs[i].rr; is_compressed_instruction = vecs[i].comp;
      read_data = vecs[i].data; flush_in = vecs[i].fl; flush_pc = vecs[i].fpc;
      inst_ready = vecs[i].ir;
      @(negedge clk_in);
      check($sformatf("v%0d_is_reading", i), 32'(is_reading), 32'(vecs[i].e_rd));
      if (vecs[i].e_rd) check($sformatf("v%0d_read_addr", i), read_addr, vecs[i].e_addr);
      check($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
        check($sformatf("v%0d_inst_data", i), inst_data, vecs[i].e_data);
        check($sformatf("v%0d_inst_comp", i), 32'(inst_is_compressed), 32'(vecs[i].e_comp));
      end
    end

    // Reset in the middle of an outstanding request
    rdy_in = 1'b1; is_ready = 1'b1; is_compressed_instruction = 1'b1;
    read_data = 32'h13; flush_in = 1'b0; inst_ready = 1'b0;
    @(negedge clk_in);
    check("pre_rst_read_addr", read_addr, 32'h2);
    is_ready = 1'b0; is_compressed_instruction = 1'b0;
    rst_in = 1'b0;
    #1;
    check("midrst_is_reading", 32'(is_reading), 32'h0);
    check("midrst_read_addr", read_addr, 32'h0);
    check("midrst_inst_valid", 32'(inst_valid), 32'h0);
    check("midrst_inst_data", inst_data, 32'h0);
    check("midrst_inst_pc", inst_pc, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("post_rst_is_reading", 32'(is_reading), 32'h1);
    check("post_rst_read_addr", read_addr, 32'h0);
    check("post_rst_inst_valid", 32'(inst_valid), 32'h0);

    // Randomized run against the stream model
    exp_q.delete();
    fetch_pc = 32'h0; stale = 1'b0; busy = 1'b0; last_rdy = 1'b0; primed = 1'b0; timer = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk_in);
      check("rand_inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
      if (primed && !is_reading) check("rand_idle_only_when_full", 32'(exp_q.size()), 32'(DEPTH));

      // Behavioural cache: 1..3 cycle latency, pulse held until the fetcher is enabled
      if (is_ready && last_rdy) begin is_ready = 1'b0; busy = 1'b0; end
      if (!busy && is_reading) begin busy = 1'b1; timer = $urandom_range(0, 2); end
      if (busy && !is_ready) begin
        if (timer == 0) begin
          is_ready = 1'b1;
          read_data = mem_word(read_addr);
          is_compressed_instruction = mem_comp(read_addr);
        end else timer--;
      end

      rdy_in     = ($urandom_range(0, 9) != 0);
      inst_ready = ($urandom_range(0, 9) < 6);
      flush_in   = ($urandom_range(0, 39) == 0);
      flush_pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFE);
      last_rdy   = rdy_in;

      if (rdy_in) begin
        primed = 1'b1;
        if (flush_in) begin
          exp_q.delete();
          stale    = is_reading && !is_ready;
          fetch_pc = flush_pc;
        end else begin
          if (inst_ready && exp_q.size() != 0) begin
            check("rand_pop_pc", inst_pc, exp_q[0].pc);
            check("rand_pop_data", inst_data, exp_q[0].data);
            check("rand_pop_comp", 32'(inst_is_compressed), 32'(exp_q[0].comp));
            void'(exp_q.pop_front());
          end
          if (is_ready) begin
            if (stale) stale = 1'b0;
            else begin
              ent_t e;
              check("rand_req_addr", read_addr, fetch_pc);
              e.pc = fetch_pc; e.data = mem_inst(fetch_pc); e.comp = mem_comp(fetch_pc);
              exp_q.push_back(e);
              check("rand_no_overflow", 32'(exp_q.size() <= DEPTH), 32'h1);
              fetch_pc = fetch_pc + (e.comp ? 32'd2 : 32'd4);
            end
          end
        end
      end
    end

    @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetcher.md
# instruction_fetcher

Front-end fetch unit driving the requester side of the instruction cache's read interface. It holds the architectural fetch PC and issues one read request at a time on `read_addr`/`is_reading`. It consumes `read_data`/`is_ready`/`is_compressed_instruction`, advances the PC by 2 or 4, and buffers fetched instructions in a small FIFO toward the decoder. A flush/redirect port lets the branch/commit logic restart fetch at a new PC and discards stale in-flight responses.

## Interface
- `QUEUE_DEPTH`, 4: instruction FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0: fetch PC after reset.
- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: ready; when low, all state freezes and all inputs are ignored.
- `read_addr` out 32: cache request address, registered.
- `is_reading` out 1: request outstanding, registered.
- `read_data` in 32: instruction word, valid when `is_ready`=1.
- `is_ready` in 1: one-cycle response pulse.
- `is_compressed_instruction` in 1: response is a 16-bit RVC instruction, valid with `is_ready`.
- `flush_in` in 1: redirect pulse.
- `flush_pc` in 32: redirect target, 2-byte aligned.
- `inst_valid` out 1: FIFO head is valid.
- `inst_data` out 32: head instruction; `[31:16]`=0 when compressed.
- `inst_pc` out 32: head PC.
- `inst_is_compressed` out 1: head is RVC.
- `inst_ready` in 1: decoder accepts the head; pop when `inst_valid & inst_ready`.

## Operation
- State `IDLE`: no request outstanding. State `WAIT`: request outstanding, result kept. State `DISCARD`: request outstanding, result dropped.
- **Request rule:** issue a request only if `count + 1 <= QUEUE_DEPTH` after this cycle's pop and push. The outstanding request counts as one reserved slot.
- **Holding a request:** while in `WAIT`/`DISCARD`, `is_reading`=1 and `read_addr` stays constant until `is_ready`. The cache owns the latency, which is at least 1 cycle.
- **`WAIT` with `is_ready`:**
  - Push `{read_data masked, pc, is_compressed_instruction}`.
  - `pc` += 2 if compressed, else 4, with modulo 2^32 wrap.
  - If there is room for another entry, stay in `WAIT` with the new `read_addr` on the next cycle (`is_reading` stays 1, back-to-back). Otherwise go to `IDLE` with `is_reading`=0.
- **`IDLE`:** when the request rule allows, go to `WAIT` with `is_reading`=1 and `read_addr`=`pc` on the next cycle.
- **Flush** (`flush_in`=1 and `rdy_in`=1): clear the FIFO, including any same-cycle pop or push, and set `pc`=`flush_pc`.
  - Request outstanding and no `is_ready` this cycle: go to `DISCARD`.
  - Otherwise (incl. `is_ready` in the same cycle, whose data is dropped): go to `WAIT`, presenting `flush_pc` next cycle.
- **`DISCARD`:** on `is_ready`, drop the data and go to `WAIT` at `pc`. A further flush in `DISCARD` only updates `pc`.
- **Simultaneous pop and push on a full FIFO:** allowed, count unchanged.

## Timing
- **Reset values:** `is_reading`=0, `read_addr`=`RESET_PC`, `pc`=`RESET_PC`, state `IDLE`, FIFO empty, `inst_valid`=0. `inst_data`, `inst_pc` and `inst_is_compressed` are 0.
- **After `rst_in` deasserts:** edge 1 sets `is_reading`=1 with `read_addr`=`RESET_PC`.
- **Push to visibility:** an entry pushed at edge N shows `inst_valid`=1 after edge N. FIFO outputs are registered head reads with no combinational path from `is_ready`.
- **Reset mid-request:** return immediately to reset values. The team's cache must also be reset in the same cycle.
- **`rdy_in`=0:** all registers hold; outputs are unchanged; `is_ready` and `flush_in` are ignored.

## Test plan
- **Reset, then a cache with 1-cycle latency returning 32'h00000013 (non-RVC) forever, `inst_ready`=1:** addresses 0, 4, 8… on consecutive requests; each `inst_pc` matches its address.
- **Mixed stream:** responses RVC, RVC, 32-bit, with `RESET_PC`=32'h80000000 → `read_addr` sequence 80000000, 80000002, 80000004, 80000008. RVC `inst_data` upper half is 0.
- **`inst_ready`=0 with `QUEUE_DEPTH`=4:** exactly 4 responses are accepted, then `is_reading`=0. One pop re-issues exactly one request.
- **Flush during an outstanding request** (cache latency 3, `flush_pc`=32'h100 one cycle after issue): the old response is dropped and the FIFO stays empty. The next `read_addr`=32'h100, and the first delivered `inst_pc`=32'h100.
- **`flush_in` and `is_ready` in the same cycle with 2 entries queued:** FIFO empty on the next cycle, response dropped, `is_reading`=1 at `flush_pc`.
- **`rdy_in` low for 5 cycles mid-`WAIT` with `is_ready`/`flush_in` pulsed:** no state change. Fetch resumes identically after `rdy_in` returns high.
